// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the DRAM port arbiter: FSM state encoding, held-request record, funct3 size codes.
package dram_port_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT0 = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } arb_state_t;

    // Fields latched from the winning port at grant time.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  ctrl;
    } dram_req_t;

    localparam logic [2:0] FUNCT3_LB____ = 3'b000;
    localparam logic [2:0] FUNCT3_LH____ = 3'b001;
    localparam logic [2:0] FUNCT3_LW____ = 3'b010;
    localparam logic [2:0] FUNCT3_LBU___ = 3'b100;
    localparam logic [2:0] FUNCT3_LHU___ = 3'b101;
    localparam logic [2:0] FUNCT3_SB____ = 3'b000;
    localparam logic [2:0] FUNCT3_SH____ = 3'b001;
    localparam logic [2:0] FUNCT3_SW____ = 3'b010;

    localparam int unsigned AGE_W = 4;

endpackage

// File: rtl/dram_port_arbiter_arb_age.sv
// m_arb_age: saturating count of port-1 arbitration losses; raises force_win at LIMIT.
// Only instantiated when DRAM_ARB_STARVE_EN is defined.
module m_arb_age
    import dram_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic CLK,
    input  logic RST_X,
    input  logic inc,
    input  logic clr,
    output logic force_win
);

    logic [AGE_W-1:0] count;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {AGE_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign force_win = (count >= AGE_W'(LIMIT));

endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: one-outstanding-transaction arbiter between MMU (port 0) and loader/DMA (port 1).
// Define DRAM_ARB_STARVE_EN to let port 1 win after STARVE_LIMIT consecutive losses.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        w_req0,
    input  logic        w_req1,
    input  logic [31:0] w_addr0,
    input  logic [31:0] w_addr1,
    input  logic [31:0] w_wdata0,
    input  logic [31:0] w_wdata1,
    input  logic        w_we0,
    input  logic        w_we1,
    input  logic [2:0]  w_ctrl0,
    input  logic [2:0]  w_ctrl1,
    output logic        w_done0,
    output logic        w_done1,
    output logic [31:0] w_rdata0,
    output logic [31:0] w_rdata1,
    output logic [31:0] w_dram_addr,
    output logic [31:0] w_dram_wdata,
    output logic [2:0]  w_dram_ctrl,
    output logic        w_dram_we_t,
    output logic        w_dram_le,
    input  logic [31:0] w_dram_odata,
    input  logic        w_dram_busy,
    output logic        w_arb_owner,
    output logic        w_arb_busy
);

    // The age counter is 4 bits wide, so the limit must fit in it.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dram_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    arb_state_t state, state_nx;
    dram_req_t  held;
    logic       grant;
    logic       grant_port;
    logic       force1;
    logic       finish;

`ifdef DRAM_ARB_STARVE_EN
    m_arb_age #(
        .LIMIT     (STARVE_LIMIT)
    ) u_arb_age (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .inc       (grant && !grant_port && w_req1),
        .clr       (grant && grant_port),
        .force_win (force1)
    );
`else
    assign force1 = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_nx   = state;
        grant      = 1'b0;
        grant_port = 1'b0;
        case (state)
            S_IDLE: begin
                if ((w_req0 || w_req1) && !w_dram_busy) begin
                    grant      = 1'b1;
                    grant_port = !w_req0 || (force1 && w_req1);
                    state_nx   = S_ISSUE;
                end
            end
            S_ISSUE: state_nx = S_WAIT0;
            S_WAIT0: state_nx = S_WAIT;
            S_WAIT: begin
                if (!w_dram_busy) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign finish = (state == S_WAIT) && !w_dram_busy;

    // NOTE: all flops, including the holding and rdata registers, clear on reset.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state       <= S_IDLE;
            held        <= '0;
            w_arb_owner <= 1'b0;
            w_rdata0    <= '0;
            w_rdata1    <= '0;
            w_done0     <= 1'b0;
            w_done1     <= 1'b0;
        end else begin
            state   <= state_nx;
            w_done0 <= finish && !w_arb_owner;
            w_done1 <= finish &&  w_arb_owner;
            if (grant) begin
                w_arb_owner <= grant_port;
                held        <= grant_port
                             ? '{addr: w_addr1, wdata: w_wdata1, we: w_we1, ctrl: w_ctrl1}
                             : '{addr: w_addr0, wdata: w_wdata0, we: w_we0, ctrl: w_ctrl0};
            end
            if (finish && !held.we) begin
                if (w_arb_owner) w_rdata1 <= w_dram_odata;
                else             w_rdata0 <= w_dram_odata;
            end
        end
    end

    // Address/data/size stay on the held values; only the strobes are gated to ISSUE.
    assign w_dram_addr  = held.addr;
    assign w_dram_wdata = held.wdata;
    assign w_dram_ctrl  = held.ctrl;
    assign w_dram_we_t  = (state == S_ISSUE) &&  held.we;
    assign w_dram_le    = (state == S_ISSUE) && !held.we;
    assign w_arb_busy   = (state != S_IDLE);

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed self-checking bench for dram_port_arbiter (STARVE_LIMIT = 3).
// Expected grant order depends on whether DRAM_ARB_STARVE_EN is defined.
module tb_dram_port_arbiter;
    import dram_port_arbiter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_X;
    logic        w_req0, w_req1;
    logic [31:0] w_addr0, w_addr1, w_wdata0, w_wdata1;
    logic        w_we0, w_we1;
    logic [2:0]  w_ctrl0, w_ctrl1;
    logic        w_done0, w_done1;
    logic [31:0] w_rdata0, w_rdata1;
    logic [31:0] w_dram_addr, w_dram_wdata;
    logic [2:0]  w_dram_ctrl;
    logic        w_dram_we_t, w_dram_le;
    logic [31:0] w_dram_odata;
    logic        w_dram_busy;
    logic        w_arb_owner, w_arb_busy;

    int n_checks = 0;
    int n_errors = 0;

    dram_port_arbiter #(.STARVE_LIMIT(3)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .w_req0(w_req0), .w_req1(w_req1),
        .w_addr0(w_addr0), .w_addr1(w_addr1),
        .w_wdata0(w_wdata0), .w_wdata1(w_wdata1),
        .w_we0(w_we0), .w_we1(w_we1),
        .w_ctrl0(w_ctrl0), .w_ctrl1(w_ctrl1),
        .w_done0(w_done0), .w_done1(w_done1),
        .w_rdata0(w_rdata0), .w_rdata1(w_rdata1),
        .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata),
        .w_dram_ctrl(w_dram_ctrl), .w_dram_we_t(w_dram_we_t),
        .w_dram_le(w_dram_le), .w_dram_odata(w_dram_odata),
        .w_dram_busy(w_dram_busy),
        .w_arb_owner(w_arb_owner), .w_arb_busy(w_arb_busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (w_arb_busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, w_arb_busy}, 32'd0);
    endtask

    logic exp_owner [5];
    logic got_owner [5];
    int   n_grants;

    initial begin
        RST_X = 1'b0;
        w_req0 = 0; w_req1 = 0; w_we0 = 0; w_we1 = 0;
        w_addr0 = '0; w_addr1 = '0; w_wdata0 = '0; w_wdata1 = '0;
        w_ctrl0 = '0; w_ctrl1 = '0; w_dram_odata = '0; w_dram_busy = 0;
        #1;
        check("rst_busy",  {31'd0, w_arb_busy},  32'd0);
        check("rst_owner", {31'd0, w_arb_owner}, 32'd0);
        check("rst_done",  {30'd0, w_done1, w_done0}, 32'd0);
        check("rst_strobe", {30'd0, w_dram_we_t, w_dram_le}, 32'd0);
        check("rst_addr",  w_dram_addr, 32'd0);
        tick(); tick();
        RST_X = 1'b1;

        // Port-0 load, busy high for two WAIT cycles
        w_req0 = 1; w_addr0 = 32'h8000_1000; w_ctrl0 = FUNCT3_LW____; w_we0 = 0;
        tick();                                                   // edge 1
        check("ld_le_issue", {31'd0, w_dram_le}, 32'd1);
        check("ld_we_issue", {31'd0, w_dram_we_t}, 32'd0);
        check("ld_addr", w_dram_addr, 32'h8000_1000);
        check("ld_ctrl", {29'd0, w_dram_ctrl}, {29'd0, FUNCT3_LW____});
        check("ld_owner", {31'd0, w_arb_owner}, 32'd0);
        w_dram_busy = 1;
        tick();                                                   // edge 2
        check("ld_le_once", {31'd0, w_dram_le}, 32'd0);
        tick(); tick(); tick();                                   // edges 3..5
        check("ld_done_early", {31'd0, w_done0}, 32'd0);
        check("ld_busy_wait", {31'd0, w_arb_busy}, 32'd1);
        w_dram_busy = 0; w_dram_odata = 32'hDEAD_BEEF;
        tick();                                                   // edge 6
        check("ld_done6", {31'd0, w_done0}, 32'd1);
        check("ld_done1_quiet", {31'd0, w_done1}, 32'd0);
        check("ld_rdata", w_rdata0, 32'hDEAD_BEEF);
        w_req0 = 0; w_dram_odata = 32'h0BAD_0BAD;
        tick();
        check("ld_done_pulse", {31'd0, w_done0}, 32'd0);
        check("ld_idle", {31'd0, w_arb_busy}, 32'd0);
        check("ld_rdata_held", w_rdata0, 32'hDEAD_BEEF);

        // Port-1 store, busy never high
        w_req1 = 1; w_addr1 = 32'h8000_0004; w_wdata1 = 32'h1234_5678;
        w_ctrl1 = FUNCT3_SW____; w_we1 = 1; w_dram_odata = 32'hCAFE_F00D;
        tick();                                                   // edge 1
        check("st_we", {31'd0, w_dram_we_t}, 32'd1);
        check("st_le", {31'd0, w_dram_le}, 32'd0);
        check("st_addr", w_dram_addr, 32'h8000_0004);
        check("st_wdata", w_dram_wdata, 32'h1234_5678);
        check("st_owner", {31'd0, w_arb_owner}, 32'd1);
        tick(); tick();                                           // edges 2,3
        check("st_we_off", {31'd0, w_dram_we_t}, 32'd0);
        check("st_done_early", {31'd0, w_done1}, 32'd0);
        tick();                                                   // edge 4
        check("st_done4", {31'd0, w_done1}, 32'd1);
        check("st_done0_quiet", {31'd0, w_done0}, 32'd0);
        check("st_rdata1", w_rdata1, 32'd0);
        w_req1 = 0; w_we1 = 0;
        tick();

        // Simultaneous loads: port 0 first, port 1 in the following IDLE cycle
        w_req0 = 1; w_addr0 = 32'h0000_00A0; w_we0 = 0;
        w_req1 = 1; w_addr1 = 32'h0000_00A1; w_we1 = 0;
        w_dram_odata = 32'h1111_1111;
        tick();
        check("sim_owner0", {31'd0, w_arb_owner}, 32'd0);
        check("sim_addr0", w_dram_addr, 32'h0000_00A0);
        tick(); tick(); tick();
        check("sim_done0", {31'd0, w_done0}, 32'd1);
        check("sim_rdata0", w_rdata0, 32'h1111_1111);
        w_req0 = 0;
        tick();
        check("sim_gap_idle", {31'd0, w_arb_busy}, 32'd0);
        check("sim_gap_owner", {31'd0, w_arb_owner}, 32'd0);
        w_dram_odata = 32'h2222_2222;
        tick();
        check("sim_owner1", {31'd0, w_arb_owner}, 32'd1);
        check("sim_addr1", w_dram_addr, 32'h0000_00A1);
        check("sim_le1", {31'd0, w_dram_le}, 32'd1);
        tick(); tick(); tick();
        check("sim_done1", {31'd0, w_done1}, 32'd1);
        check("sim_rdata1", w_rdata1, 32'h2222_2222);
        check("sim_rdata0_kept", w_rdata0, 32'h1111_1111);
        w_req1 = 0;
        tick();

        // Both requests held: record the owner of five consecutive grants
`ifdef DRAM_ARB_STARVE_EN
        exp_owner = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        w_req0 = 1; w_req1 = 1;
        n_grants = 0;
        for (int c = 0; c < 60 && n_grants < 5; c++) begin
            tick();
            if (w_dram_le || w_dram_we_t) begin
                got_owner[n_grants] = w_arb_owner;
                n_grants++;
            end
        end
        check("starve_ngrants", n_grants, 32'd5);
        for (int g = 0; g < 5; g++) begin
            if (g < n_grants)
                check($sformatf("starve_grant%0d", g), {31'd0, got_owner[g]}, {31'd0, exp_owner[g]});
        end
        w_req0 = 0; w_req1 = 0;
        wait_idle("starve_drain", 10);

        // DRAM busy in IDLE blocks grants; a request dropped before grant is ignored
        w_dram_busy = 1;
        w_req1 = 1; w_addr1 = 32'h0000_0BB0; w_we1 = 0;
        tick();
        w_req1 = 0;
        w_req0 = 1; w_addr0 = 32'h0000_0C00; w_wdata0 = 32'hA5A5_A5A5; w_we0 = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bsy_nogrant%0d", c), {31'd0, w_arb_busy}, 32'd0);
            check($sformatf("bsy_nostrobe%0d", c), {30'd0, w_dram_we_t, w_dram_le}, 32'd0);
        end
        w_dram_busy = 0;
        tick();
        check("bsy_grant", {31'd0, w_arb_busy}, 32'd1);
        check("bsy_we", {31'd0, w_dram_we_t}, 32'd1);
        check("bsy_owner", {31'd0, w_arb_owner}, 32'd0);
        check("bsy_addr", w_dram_addr, 32'h0000_0C00);
        tick(); tick(); tick();
        check("bsy_done0", {31'd0, w_done0}, 32'd1);
        w_req0 = 0; w_we0 = 0;
        tick();
        check("bsy_no_p1", {31'd0, w_arb_busy}, 32'd0);

        // Reset asserted asynchronously while in WAIT
        w_req0 = 1; w_addr0 = 32'h0000_0D00; w_we0 = 0;
        tick();
        w_dram_busy = 1;
        tick(); tick(); tick();
        #2;
        RST_X = 1'b0;
        #1;
        check("rstw_busy", {31'd0, w_arb_busy}, 32'd0);
        check("rstw_addr", w_dram_addr, 32'd0);
        check("rstw_rdata0", w_rdata0, 32'd0);
        check("rstw_rdata1", w_rdata1, 32'd0);
        check("rstw_outs", {28'd0, w_done0, w_done1, w_dram_le, w_dram_we_t}, 32'd0);
        w_req0 = 0; w_dram_busy = 0;
        tick(); tick();
        check("rstw_no_done", {30'd0, w_done1, w_done0}, 32'd0);
        RST_X = 1'b1;
        tick();
        w_req0 = 1; w_addr0 = 32'h0000_0E00; w_we0 = 0; w_dram_odata = 32'h55AA_55AA;
        tick();
        check("post_le", {31'd0, w_dram_le}, 32'd1);
        check("post_addr", w_dram_addr, 32'h0000_0E00);
        tick(); tick();
        check("post_done_early", {31'd0, w_done0}, 32'd0);
        tick();
        check("post_done", {31'd0, w_done0}, 32'd1);
        check("post_rdata", w_rdata0, 32'h55AA_55AA);
        w_req0 = 0;
        tick();
        check("post_idle", {31'd0, w_arb_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Two-requester arbiter for the single DRAM port. It sits between the MMU's DRAM-side interface (port 0: fetch, load/store and page-walk traffic) and a second bus master (port 1: loader/DMA). It accepts one outstanding transaction at a time, drives the DRAM strobes for exactly one cycle, and waits out `w_dram_busy`. It then returns read data with a one-cycle done pulse to the owning port.

## Interface
- `STARVE_LIMIT`, default 8: consecutive port-1 losses before port 1 is forced to win (used only with `DRAM_ARB_STARVE_EN`).
- `CLK` input 1: single clock, rising edge.
- `RST_X` input 1: asynchronous, active-low reset.
- `w_req0`, `w_req1` input 1: request, held high until the matching done.
- `w_addr0`, `w_addr1` input 32: byte address.
- `w_wdata0`, `w_wdata1` input 32: write data.
- `w_we0`, `w_we1` input 1: 1 = store, 0 = load.
- `w_ctrl0`, `w_ctrl1` input 3: funct3 size code (`FUNCT3_LW____` etc.).
- `w_done0`, `w_done1` output 1: one-cycle completion pulse.
- `w_rdata0`, `w_rdata1` output 32: registered read data, valid while done is high, held afterwards.
- `w_dram_addr` output 32: DRAM address.
- `w_dram_wdata` output 32: DRAM write data.
- `w_dram_ctrl` output 3: DRAM size code.
- `w_dram_we_t` output 1: write strobe.
- `w_dram_le` output 1: load strobe.
- `w_dram_odata` input 32: DRAM read data.
- `w_dram_busy` input 1: DRAM controller busy.
- `w_arb_owner` output 1: port of the current or last grant.
- `w_arb_busy` output 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE(0)
  - ISSUE(1)
  - WAIT0(2)
  - WAIT(3)
  - DONE(4)
- IDLE:
  - Grants only when at least one request is high and `w_dram_busy`=0.
  - Winner: port 0 if `w_req0`, otherwise port 1.
  - Latches the winner's addr, wdata, we and ctrl into holding registers.
  - Sets `w_arb_owner` and goes to ISSUE.
- ISSUE:
  - Drives the held fields onto the DRAM outputs.
  - `w_dram_we_t` = held we; `w_dram_le` = !held we.
  - Goes to WAIT0 unconditionally.
- WAIT0: one mandatory cycle covering the DRAM controller's busy-rise latency. `w_dram_busy` is ignored. Goes to WAIT.
- WAIT:
  - Stays while `w_dram_busy`=1.
  - When busy=0, captures `w_dram_odata` into the owner's rdata register (loads only) and goes to DONE.
- DONE: pulses the owner's done, then returns to IDLE.
- Outside ISSUE:
  - `w_dram_we_t` and `w_dram_le` are 0.
  - `w_dram_addr`, `w_dram_wdata` and `w_dram_ctrl` keep the held values.
- Request rules:
  - A request dropped before grant is ignored.
  - After grant, the transaction completes even if the request drops.
  - A request still high in the DONE cycle is not re-granted until IDLE.
- Reset (async, any state):
  - State returns to IDLE.
  - All outputs and holding registers go to 0; `w_arb_owner`=0.
  - An in-flight DRAM access is abandoned and no done is issued; the requester re-requests.

## Timing
- Minimum load/store latency, request to done: 4 cycles (IDLE grant, ISSUE, WAIT0, WAIT with busy=0, then DONE). Done is seen at edge 4 after the request is sampled.
- Every additional busy cycle in WAIT adds one cycle.
- Back-to-back throughput: one transaction per 5 cycles at best (DONE→IDLE is a full cycle).
- Simultaneous requests in IDLE: resolved in the same cycle; no lost-request cycle.

## Configuration
- `DRAM_ARB_STARVE_EN` defined:
  - A 4-bit age counter increments when port 1 requests and port 0 wins.
  - It clears when port 1 is granted.
  - When the count reaches `STARVE_LIMIT`, port 1 wins the next arbitration even with `w_req0` high.
  - Reset value 0.
- `DRAM_ARB_STARVE_EN` undefined: strict fixed priority to port 0, with no counter logic.

## Structure
- State encodings and the strobe-select localparams go in `define.vh` alongside `FUNCT3_*`.
- One sub-module, `m_arb_age`, is natural: the saturating age counter with a force output. It is instantiated only under `DRAM_ARB_STARVE_EN`.

## Test plan
- Single port-0 load:
  - Stimulus: addr 0x80001000, ctrl LW; DRAM returns 0xDEADBEEF with busy high for 2 cycles.
  - Response: `w_dram_le` high for exactly 1 cycle; `w_done0` on cycle 6; `w_rdata0`=0xDEADBEEF.
- Port-1 store:
  - Stimulus: addr 0x80000004, wdata 0x12345678, ctrl SW, busy never high.
  - Response: `w_dram_we_t` pulse with matching addr/wdata; `w_done1` at cycle 4; `w_rdata1` unchanged.
- Simultaneous req0 and req1:
  - Response: port 0 completes first; port 1 is granted in the IDLE cycle following port-0 DONE; `w_arb_owner` goes 0 then 1.
- Starvation, with `DRAM_ARB_STARVE_EN` and `STARVE_LIMIT`=3:
  - Stimulus: req0 and req1 held continuously.
  - Response: port 0 wins 3 times, port 1 wins the 4th grant, and the counter returns to 0.
- Grant while DRAM busy:
  - Stimulus: `w_dram_busy`=1 in IDLE with req0 high.
  - Response: no grant until busy=0; no strobes meanwhile.
- Reset mid-WAIT:
  - Stimulus: assert `RST_X`=0 asynchronously.
  - Response: state IDLE and all outputs 0 immediately; no done pulse. After release, a fresh req0 completes normally.
